// File: rtl/reg_file_pkg.sv
// Shared defaults, FSM state type and address-legality helper for the
// multi-ported register file.
package reg_file_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF  = 2;
  localparam int NWR_DEF  = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Address 0 is hardwired zero and addresses past the array are not backed.
  function automatic logic addr_ok(input logic [6:0] a, input int nreg);
    return (a != 7'd0) && (int'(a) < nreg);
  endfunction
endpackage

// File: rtl/reg_file_bypass_mux.sv
// One read lane: array word with write-first bypass, the highest write port
// taking priority; forced to zero when not ready or for illegal addresses.
module reg_file_bypass_mux
  import reg_file_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NWR  = NWR_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                en,
  input  logic [AW-1:0]       i_raddr,
  input  logic [XLEN-1:0]     i_word,
  input  logic [NWR-1:0]      i_we,
  input  logic [NWR*AW-1:0]   i_waddr,
  input  logic [NWR*XLEN-1:0] i_wdata,
  output logic [XLEN-1:0]     o_data
);
  always_comb begin
    o_data = i_word;
    for (int k = 0; k < NWR; k++) begin
      if (i_we[k] && (i_waddr[k*AW +: AW] == i_raddr) &&
          addr_ok(7'(i_waddr[k*AW +: AW]), NREG))
        o_data = i_wdata[k*XLEN +: XLEN];
    end
    if (!en || !addr_ok(7'(i_raddr), NREG))
      o_data = '0;
  end
endmodule

// File: rtl/reg_file_mp.sv
// Multi-ported flop register file with x0 hardwired to zero and a
// post-reset sweep that clears registers 1..NREG-1 before accepting writes.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = NRD_DEF,
  parameter int NWR  = NWR_DEF,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ready,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata
);
  state_t            r_state;
  logic [AW-1:0]     r_ptr;
  logic [XLEN-1:0]   r_mem [1:NREG-1];
  logic              w_rdy;

  assign w_rdy = (r_state == READY) && !reset;
  assign ready = w_rdy;

  // Later ports are applied last, so the highest-index port wins a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR;
      r_ptr   <= AW'(1);
    end else if (r_state == CLEAR) begin
      r_mem[r_ptr] <= '0;
      r_ptr        <= r_ptr + AW'(1);
      if (r_ptr == AW'(NREG-1))
        r_state <= READY;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (we[k] && addr_ok(7'(waddr[k*AW +: AW]), NREG))
          r_mem[waddr[k*AW +: AW]] <= wdata[k*XLEN +: XLEN];
      end
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0]   w_raddr;
    logic [XLEN-1:0] w_word;

    assign w_raddr = raddr[j*AW +: AW];
    assign w_word  = addr_ok(7'(w_raddr), NREG) ? r_mem[w_raddr] : '0;

    reg_file_bypass_mux #(
      .XLEN (XLEN),
      .NREG (NREG),
      .NWR  (NWR),
      .AW   (AW)
    ) u_mux (
      .en      (w_rdy),
      .i_raddr (w_raddr),
      .i_word  (w_word),
      .i_we    (we),
      .i_waddr (waddr),
      .i_wdata (wdata),
      .o_data  (rdata[j*XLEN +: XLEN])
    );
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp (XLEN=32, NREG=32, 2 read / 2 write ports).
module tb_reg_file_mp;
  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt;

  reg_file_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) dut (
    .clk   (clk),
    .reset (reset),
    .ready (ready),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts sampled cycles with ready low; called #1 after the release negedge.
  task automatic wait_ready(output int c);
    c = 0;
    while (!ready && c < 100) begin
      chk("clear_rd0", rdata[31:0], 32'h0);
      c++;
      @(negedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; we = '0; waddr = '0; wdata = '0; raddr = '0;
    @(negedge clk); #1;
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_rd0", rdata[31:0], 32'h0);

    // Release reset while hammering x3 from port 0 throughout CLEAR.
    @(negedge clk);
    reset = 1'b0;
    we = 2'b01; waddr[4:0] = 5'd3; wdata[31:0] = 32'h0000_00A5; raddr[4:0] = 5'd3;
    #1;
    wait_ready(cnt);
    chk("clear_len", 32'(cnt), 32'd31);
    we = '0;

    for (int i = 1; i < 32; i++) begin
      raddr[4:0] = 5'(i);
      raddr[9:5] = 5'(32 - i);
      #1;
      chk("zero_rd0", rdata[31:0], 32'h0);
      chk("zero_rd1", rdata[63:32], 32'h0);
    end
    raddr[4:0] = 5'd3; #1;
    chk("x3_after_clear", rdata[31:0], 32'h0);

    // Write-first bypass on port 0.
    @(negedge clk);
    we = 2'b01; waddr[4:0] = 5'd5; wdata[31:0] = 32'hDEAD_BEEF; raddr[4:0] = 5'd5;
    #1; chk("x5_bypass", rdata[31:0], 32'hDEAD_BEEF);
    @(negedge clk);
    we = '0; #1; chk("x5_stored", rdata[31:0], 32'hDEAD_BEEF);

    // Same-address collision: port 1 wins both bypass and storage.
    @(negedge clk);
    we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22, 32'h11}; raddr = {5'd7, 5'd7};
    #1;
    chk("x7_bypass0", rdata[31:0], 32'h22);
    chk("x7_bypass1", rdata[63:32], 32'h22);
    @(negedge clk);
    we = '0; #1; chk("x7_stored", rdata[31:0], 32'h22);

    // x0 is hardwired.
    @(negedge clk);
    we = 2'b01; waddr[4:0] = 5'd0; wdata[31:0] = 32'hFFFF_FFFF; raddr[9:5] = 5'd0;
    #1; chk("x0_bypass", rdata[63:32], 32'h0);
    @(negedge clk);
    we = '0; #1; chk("x0_stored", rdata[63:32], 32'h0);

    // Distinct addresses on both ports, cross-read by the two lanes.
    @(negedge clk);
    we = 2'b11; waddr = {5'd8, 5'd9}; wdata = {32'h0000_8888, 32'h0000_1234};
    raddr = {5'd9, 5'd8};
    #1;
    chk("x8_bypass", rdata[31:0], 32'h0000_8888);
    chk("x9_bypass", rdata[63:32], 32'h0000_1234);
    @(negedge clk);
    we = '0; #1;
    chk("x8_stored", rdata[31:0], 32'h0000_8888);
    chk("x9_stored", rdata[63:32], 32'h0000_1234);
    raddr[4:0] = 5'd5; #1;
    chk("x5_kept", rdata[31:0], 32'hDEAD_BEEF);

    // Reset, then reset again with the sweep at pointer 10 and a write pending.
    @(negedge clk);
    reset = 1'b1; #1;
    chk("rst2_ready", 32'(ready), 32'h0);
    chk("rst2_rd1", rdata[63:32], 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (9) @(negedge clk);
    #1; chk("mid_clear_ready", 32'(ready), 32'h0);
    reset = 1'b1;
    we = 2'b01; waddr[4:0] = 5'd9; wdata[31:0] = 32'h0000_0BAD; raddr[4:0] = 5'd9;
    #1;
    chk("rst3_ready", 32'(ready), 32'h0);
    chk("rst3_bypass", rdata[31:0], 32'h0);
    @(negedge clk);
    reset = 1'b0; we = '0; #1;
    wait_ready(cnt);
    chk("reclear_len", 32'(cnt), 32'd31);
    raddr = {5'd5, 5'd9}; #1;
    chk("x9_after_reset", rdata[31:0], 32'h0);
    chk("x5_after_reset", rdata[63:32], 32'h0);
    raddr = {5'd8, 5'd7}; #1;
    chk("x7_after_reset", rdata[31:0], 32'h0);
    chk("x8_after_reset", rdata[63:32], 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count, legal range 2..64.
REQ-003 SHALL have parameter NRD, default 2, read-port count, legal range 1..4.
REQ-004 SHALL have parameter NWR, default 2, write-port count, legal range 1..2.
REQ-005 SHALL derive local constant AW = clog2(NREG), the address width.
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 ready  output  1  high when the array is cleared and accepting writes.
REQ-009 we  input  NWR  per-port write enable.
REQ-010 waddr  input  NWR*AW  write addresses; port k occupies bits [k*AW +: AW].
REQ-011 wdata  input  NWR*XLEN  write data; port k occupies bits [k*XLEN +: XLEN].
REQ-012 raddr  input  NRD*AW  read addresses, packed as for waddr.
REQ-013 rdata  output  NRD*XLEN  read data, combinational, packed as for wdata.

Function
REQ-014 SHALL implement a two-state FSM: CLEAR and READY.
REQ-015 SHALL enter CLEAR with clear pointer = 1 on any clock edge where reset = 1, from either state.
REQ-016 In CLEAR, SHALL write 0 to register[pointer] and increment the pointer each cycle.
REQ-017 SHALL move from CLEAR to READY on the edge that clears register NREG-1, so CLEAR lasts NREG-1 cycles after reset is released.
REQ-018 ready SHALL be 0 in CLEAR and while reset = 1, and 1 in READY.
REQ-019 In CLEAR, SHALL ignore all write ports and drive every rdata lane to 0.
REQ-020 In READY, port k SHALL write wdata[k] to register waddr[k] on the rising edge when we[k] = 1.
REQ-021 Writes to address 0 SHALL be discarded; reads of address 0 SHALL return 0.
REQ-022 Writes or reads with address >= NREG SHALL be discarded or return 0, respectively.
REQ-023 If two ports write the same address in the same cycle, the highest-index port SHALL win.
REQ-024 Reads SHALL be write-first: a read lane whose raddr matches an enabled, legal, nonzero waddr in the same READY cycle SHALL return that wdata, with the highest-index matching port winning.
REQ-025 Read latency SHALL be 0 cycles (combinational from raddr, array and write ports).
REQ-026 Without bypass, a written value SHALL be visible on rdata starting the cycle after the write edge.

Reset
REQ-027 During reset and CLEAR, SHALL hold ready = 0 and all rdata = 0.
REQ-028 After reset and CLEAR, every register SHALL read 0.
REQ-029 A reset asserted mid-CLEAR or mid-write SHALL restart the sweep at pointer 1 and drop the write in the reset cycle.

Structure
REQ-030 A shared package reg_file_pkg SHALL hold the XLEN/NREG/NRD/NWR defaults and the FSM state enum {CLEAR, READY}.
REQ-031 Each read lane SHALL be one instance of sub-module reg_file_bypass_mux, which takes the array word and write ports and outputs lane data.
REQ-032 Storage SHALL be a flip-flop array of NREG x XLEN; register 0 need not be physically stored.

Verification
REQ-033 Reset for 1 cycle with NREG = 32 -> ready = 0 for 31 cycles, then 1; read addresses 1..31 all return 0.
REQ-034 Port0 writes x5 = 0xDEADBEEF while raddr0 = 5 in the same cycle -> rdata0 = 0xDEADBEEF in that cycle and the following cycle.
REQ-035 Port0 writes x7 = 0x11 and port1 writes x7 = 0x22 in the same cycle -> bypass gives 0x22; the next-cycle read of x7 gives 0x22.
REQ-036 Write x0 = 0xFFFFFFFF with raddr1 = 0 -> rdata1 = 0 in that cycle and afterwards.
REQ-037 Write x3 = 0xA5 during CLEAR, then read x3 after ready rises -> 0.
REQ-038 Write x9 = 0x1234, reset at CLEAR pointer 10, wait for ready -> x9 reads 0 and ready rises exactly 31 cycles after reset is released.
